// File: rtl/special_walls_map.sv
// Writable multi-level Pac-Man wall map: a fill sequencer generates one pattern row per cycle,
// then the array serves a registered row-read port, a cell query port and a cell-clear port.
module special_walls_map #(
  parameter int WIDTH      = 80,
  parameter int HEIGHT     = 26,
  parameter int BORDER     = 4,
  parameter int FLOOR_ROWS = 4,
  localparam int RW = $clog2(HEIGHT),
  localparam int CW = $clog2(WIDTH),
  localparam int NW = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0]       level_sel,
  input  logic             load_start,
  output logic             busy,
  output logic             load_done,
  input  logic [RW-1:0]    rd_row,
  output logic [WIDTH-1:0] rd_data,
  input  logic             q_valid,
  input  logic [RW-1:0]    q_row,
  input  logic [CW-1:0]    q_col,
  output logic             q_resp_valid,
  output logic             q_hit,
  input  logic             clr_valid,
  input  logic [RW-1:0]    clr_row,
  input  logic [CW-1:0]    clr_col,
  output logic             clr_ack,
  output logic [NW-1:0]    cleared_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  localparam logic [NW-1:0] CNT_MAX = NW'(WIDTH*HEIGHT);

  logic [WIDTH-1:0] map_mem [HEIGHT];

  logic [0:0]       state_reg;
  logic [RW-1:0]    row_cnt_reg;
  logic [1:0]       level_reg;
  logic [NW-1:0]    cnt_reg;
  logic             load_done_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             q_resp_valid_reg;
  logic             q_hit_reg;
  logic             clr_ack_reg;

  // Column c lives at bit WIDTH-1-c so column 0 is the MSB / leftmost pixel.
  logic [WIDTH-1:0] border_mask;
  logic [WIDTH-1:0] plat_mask;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign border_mask[WIDTH-1-gi] = (gi < BORDER) || (gi >= WIDTH - BORDER);
      assign plat_mask[WIDTH-1-gi]   = (gi >= WIDTH / 4) && (gi < 3 * WIDTH / 4);
    end
  endgenerate

  logic [WIDTH-1:0] fill_row;
  always_comb begin
    fill_row = border_mask;
    if (int'(row_cnt_reg) >= HEIGHT - FLOOR_ROWS) fill_row = '1;
    if (level_reg == 2'd1 && int'(row_cnt_reg) < FLOOR_ROWS) fill_row = '1;
    if (level_reg == 2'd2 && int'(row_cnt_reg) == HEIGHT / 2) fill_row = fill_row | plat_mask;
  end

  assign busy = (state_reg == FILL);

  logic             rd_oob;
  logic [RW-1:0]    rd_idx;
  logic             q_in_range;
  logic [RW-1:0]    q_idx;
  logic [CW-1:0]    q_bit;
  logic [WIDTH-1:0] q_word;
  logic             clr_in_range;
  logic             clr_not_border;
  logic [RW-1:0]    clr_idx;
  logic [CW-1:0]    clr_bit;
  logic [WIDTH-1:0] clr_word;
  logic             clr_ok;

  always_comb begin
    rd_oob         = int'(rd_row) >= HEIGHT;
    rd_idx         = rd_oob ? '0 : rd_row;
    q_in_range     = (int'(q_row) < HEIGHT) && (int'(q_col) < WIDTH);
    q_idx          = q_in_range ? q_row : '0;
    q_bit          = q_in_range ? (CW'(WIDTH - 1) - q_col) : '0;
    q_word         = map_mem[q_idx];
    clr_in_range   = (int'(clr_row) < HEIGHT) && (int'(clr_col) < WIDTH);
    clr_not_border = (int'(clr_col) >= BORDER) && (int'(clr_col) < WIDTH - BORDER);
    clr_idx        = clr_in_range ? clr_row : '0;
    clr_bit        = clr_in_range ? (CW'(WIDTH - 1) - clr_col) : '0;
    clr_word       = map_mem[clr_idx];
    clr_ok         = clr_valid && clr_in_range && clr_not_border && !busy && clr_word[clr_bit];
  end

  // Fill and clear never coincide because clears are only accepted while idle.
  always_ff @(posedge Clk) begin
    if (Reset_n && busy) begin
      map_mem[row_cnt_reg] <= fill_row;
    end else if (Reset_n && clr_ok) begin
      map_mem[clr_idx][clr_bit] <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg        <= FILL;
      row_cnt_reg      <= '0;
      level_reg        <= 2'd0;
      cnt_reg          <= '0;
      load_done_reg    <= 1'b0;
      rd_data_reg      <= '1;
      q_resp_valid_reg <= 1'b0;
      q_hit_reg        <= 1'b0;
      clr_ack_reg      <= 1'b0;
    end else begin
      load_done_reg    <= 1'b0;
      clr_ack_reg      <= clr_ok;
      q_resp_valid_reg <= q_valid;
      if (q_valid) q_hit_reg <= busy || !q_in_range || q_word[q_bit];
      rd_data_reg <= (busy || rd_oob) ? '1 : map_mem[rd_idx];
      if (clr_ok && cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + NW'(1);
      // Starting a fill wipes the clear count even if a clear lands on the same edge.
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            state_reg   <= FILL;
            level_reg   <= level_sel;
            row_cnt_reg <= '0;
            cnt_reg     <= '0;
          end
        end
        default: begin
          row_cnt_reg <= row_cnt_reg + RW'(1);
          if (row_cnt_reg == RW'(HEIGHT - 1)) begin
            state_reg     <= IDLE;
            load_done_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign load_done    = load_done_reg;
  assign rd_data      = rd_data_reg;
  assign q_resp_valid = q_resp_valid_reg;
  assign q_hit        = q_hit_reg;
  assign clr_ack      = clr_ack_reg;
  assign cleared_cnt  = cnt_reg;

endmodule

// File: tb/tb_special_walls_map.sv
// Directed bench for special_walls_map: fill timing, read/query/clear ports, busy behaviour
// and reset abort of a fill, using hand-computed expected values.
module tb_special_walls_map;

  localparam logic [79:0] ALL1   = {80{1'b1}};
  localparam logic [79:0] BORD   = 80'hF000_0000_0000_0000_000F;
  localparam logic [79:0] PLAT13 = 80'hF000_0FFF_FFFF_FFF0_000F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  level_sel = 2'd0;
  logic        load_start = 1'b0;
  logic        busy;
  logic        load_done;
  logic [4:0]  rd_row = 5'd0;
  logic [79:0] rd_data;
  logic        q_valid = 1'b0;
  logic [4:0]  q_row = 5'd0;
  logic [6:0]  q_col = 7'd0;
  logic        q_resp_valid;
  logic        q_hit;
  logic        clr_valid = 1'b0;
  logic [4:0]  clr_row = 5'd0;
  logic [6:0]  clr_col = 7'd0;
  logic        clr_ack;
  logic [11:0] cleared_cnt;

  int total = 0;
  int bad = 0;
  int n;

  special_walls_map dut (
    .Clk(clk), .Reset_n(rst_n), .level_sel(level_sel), .load_start(load_start),
    .busy(busy), .load_done(load_done), .rd_row(rd_row), .rd_data(rd_data),
    .q_valid(q_valid), .q_row(q_row), .q_col(q_col), .q_resp_valid(q_resp_valid),
    .q_hit(q_hit), .clr_valid(clr_valid), .clr_row(clr_row), .clr_col(clr_col),
    .clr_ack(clr_ack), .cleared_cnt(cleared_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until busy drops; expects 26 and a load_done pulse on the falling edge.
  task automatic wait_fill(input string tag);
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_busy_cycles"}, 80'(n), 80'd26);
    chk({tag, "_load_done"}, 80'(load_done), 80'd1);
    tick();
    chk({tag, "_load_done_drop"}, 80'(load_done), 80'd0);
  endtask

  task automatic read_row(input string tag, input logic [4:0] r, input logic [79:0] exp);
    rd_row = r;
    tick();
    chk(tag, rd_data, exp);
  endtask

  task automatic query(input string tag, input logic [4:0] r, input logic [6:0] c, input logic exp);
    q_valid = 1'b1; q_row = r; q_col = c;
    tick();
    q_valid = 1'b0;
    chk({tag, "_vld"}, 80'(q_resp_valid), 80'd1);
    chk(tag, 80'(q_hit), 80'(exp));
    tick();
    chk({tag, "_vld_drop"}, 80'(q_resp_valid), 80'd0);
  endtask

  task automatic clear(input string tag, input logic [4:0] r, input logic [6:0] c,
                       input logic exp_ack, input int exp_cnt);
    clr_valid = 1'b1; clr_row = r; clr_col = c;
    tick();
    clr_valid = 1'b0;
    chk({tag, "_ack"}, 80'(clr_ack), 80'(exp_ack));
    chk({tag, "_cnt"}, 80'(cleared_cnt), 80'(exp_cnt));
  endtask

  task automatic start_fill(input logic [1:0] lvl);
    level_sel = lvl; load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    // 1: reset values, automatic level 0 fill
    tick(); tick();
    chk("rst_busy", 80'(busy), 80'd1);
    chk("rst_load_done", 80'(load_done), 80'd0);
    chk("rst_rd_data", rd_data, ALL1);
    chk("rst_q_resp_valid", 80'(q_resp_valid), 80'd0);
    chk("rst_q_hit", 80'(q_hit), 80'd0);
    chk("rst_clr_ack", 80'(clr_ack), 80'd0);
    chk("rst_cnt", 80'(cleared_cnt), 80'd0);
    rst_n = 1'b1;
    wait_fill("fill0");
    for (int i = 0; i < 3; i++) tick();
    read_row("rd_row0", 5'd0, BORD);
    read_row("rd_row22", 5'd22, ALL1);
    read_row("rd_row31", 5'd31, ALL1);

    // 2: queries on level 0
    query("q_5_2", 5'd5, 7'd2, 1'b1);
    query("q_5_10", 5'd5, 7'd10, 1'b0);
    query("q_5_79", 5'd5, 7'd79, 1'b1);
    query("q_5_80", 5'd5, 7'd80, 1'b1);

    // 3: clears
    clear("clr_22_10", 5'd22, 7'd10, 1'b1, 1);
    query("q_22_10_after", 5'd22, 7'd10, 1'b0);
    clear("clr_22_10_again", 5'd22, 7'd10, 1'b0, 1);
    clear("clr_22_2_border", 5'd22, 7'd2, 1'b0, 1);
    clear("clr_5_10_empty", 5'd5, 7'd10, 1'b0, 1);

    // 4: same-cycle query and clear of (23,40)
    q_valid = 1'b1; q_row = 5'd23; q_col = 7'd40;
    clr_valid = 1'b1; clr_row = 5'd23; clr_col = 7'd40;
    tick();
    clr_valid = 1'b0;
    chk("same_q_hit", 80'(q_hit), 80'd1);
    chk("same_clr_ack", 80'(clr_ack), 80'd1);
    chk("same_cnt", 80'(cleared_cnt), 80'd2);
    tick();
    q_valid = 1'b0;
    chk("same_next_q_hit", 80'(q_hit), 80'd0);

    // 5: level 1 fill with traffic during busy
    start_fill(2'd1);
    chk("l1_busy", 80'(busy), 80'd1);
    chk("l1_cnt_reset", 80'(cleared_cnt), 80'd0);
    n = 0;
    while (busy && n < 60) begin
      if (n == 2) begin
        rd_row = 5'd5;
        q_valid = 1'b1; q_row = 5'd5; q_col = 7'd10;
        clr_valid = 1'b1; clr_row = 5'd23; clr_col = 7'd41;
      end
      if (n == 10) load_start = 1'b1;
      tick();
      n++;
      if (n == 3) begin
        q_valid = 1'b0; clr_valid = 1'b0;
        chk("busy_rd_all1", rd_data, ALL1);
        chk("busy_q_vld", 80'(q_resp_valid), 80'd1);
        chk("busy_q_hit", 80'(q_hit), 80'd1);
        chk("busy_clr_ack", 80'(clr_ack), 80'd0);
      end
      if (n == 11) load_start = 1'b0;
    end
    chk("l1_busy_cycles", 80'(n), 80'd26);
    chk("l1_load_done", 80'(load_done), 80'd1);
    chk("l1_cnt", 80'(cleared_cnt), 80'd0);
    tick();
    chk("l1_still_idle", 80'(busy), 80'd0);
    read_row("l1_rd_row0", 5'd0, ALL1);
    read_row("l1_rd_row5", 5'd5, BORD);
    query("l1_q_23_41", 5'd23, 7'd41, 1'b1);

    // 6: level 2 fill aborted by reset at row 5
    start_fill(2'd2);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 80'(busy), 80'd1);
    wait_fill("abort_fill");
    read_row("abort_rd_row13", 5'd13, BORD);

    // full level 2 and level 3 fills for the platform row
    start_fill(2'd2);
    wait_fill("l2_fill");
    read_row("l2_rd_row13", 5'd13, PLAT13);
    read_row("l2_rd_row12", 5'd12, BORD);
    query("l2_q_13_20", 5'd13, 7'd20, 1'b1);
    query("l2_q_13_60", 5'd13, 7'd60, 1'b0);
    start_fill(2'd3);
    wait_fill("l3_fill");
    read_row("l3_rd_row13", 5'd13, BORD);
    read_row("l3_rd_row0", 5'd0, BORD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
